data_ram_responder: RTL and testbench

- Data-memory responder on the controller's RAM bus (ram_cs / ram_re / ram_we / ram_addr / data).
- Holds a DEPTH x 16 array.
- Returns read data one cycle after the address is stable and commits writes on ram_we pulses.
- Flags protocol violations and keeps access statistics for debug.

---
 rtl/data_ram_responder.sv | 134 +++++++++++++
 tb/tb_data_ram_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_responder.sv
// rtl/data_ram_responder.sv - RAM-bus data memory responder: read-ahead, write-first forwarding, access stats.
// Optional macro RAM_CLEAR_EN: zero-sweep of the whole array after every reset, busy while sweeping.
module data_ram_responder #(
   parameter int AW = 8,
   parameter int DW = 16,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ram_cs,
   input  logic          ram_re,
   input  logic          ram_we,
   input  logic [AW-1:0] ram_addr,
   input  logic [DW-1:0] ram_wdata,
   output logic [DW-1:0] ram_rdata,
   output logic          rd_valid,
   output logic          busy,
   output logic          proto_err,
   output logic [CW-1:0] rd_count,
   output logic [CW-1:0] wr_count
);
   localparam int DEPTH = 2**AW;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_ERR, S_CLEAR} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] last_addr;
   logic          valid_q;
   logic          clearing;
   logic          capture, wr_en, mem_we, both_en;
   logic          err_set, rd_start, wr_start;
   logic          mem_wr;
   logic [AW-1:0] mem_wa;
   logic [DW-1:0] mem_wd;

`ifdef RAM_CLEAR_EN
   localparam state_t S_RST = S_CLEAR;
   logic [AW-1:0] clr_addr;

   assign clearing = (state == S_CLEAR);
   assign busy     = clearing & ~rst;
   assign mem_wr   = (clearing & ~rst) | mem_we;
   assign mem_wa   = clearing ? clr_addr : ram_addr;
   assign mem_wd   = clearing ? '0 : ram_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_addr <= '0;
      end else if (clearing) begin
         clr_addr <= clr_addr + 1'b1;
      end
   end
`else
   localparam state_t S_RST = S_IDLE;

   assign clearing = 1'b0;
   assign busy     = 1'b0;
   assign mem_wr   = mem_we;
   assign mem_wa   = ram_addr;
   assign mem_wd   = ram_wdata;
`endif

   assign capture = ram_cs & ~busy;
   assign both_en = ram_cs & ram_re & ram_we;
   assign wr_en   = capture & ram_we & ~ram_re;
   // Gating on rst keeps a write whose edge meets reset assertion out of the array.
   assign mem_we  = wr_en & ~rst;

   assign rd_valid = ram_cs & valid_q & (ram_addr == last_addr);

   always_comb begin
      state_nxt = state;
      err_set   = 1'b0;
      case (state)
         S_IDLE: begin
            if (ram_cs & ram_re & ~ram_we) begin
               state_nxt = S_READ;
            end else if (ram_cs & ram_we & ~ram_re) begin
               state_nxt = S_WRITE;
            end
         end
         S_READ: begin
            if (~ram_re | ~ram_cs) state_nxt = S_IDLE;
         end
         S_WRITE: begin
            if (~ram_we | ~ram_cs) state_nxt = S_IDLE;
         end
         S_ERR: begin
            if (~ram_re & ~ram_we) state_nxt = S_IDLE;
         end
`ifdef RAM_CLEAR_EN
         S_CLEAR: begin
            err_set = ram_cs & (ram_re | ram_we);
            if (&clr_addr) state_nxt = S_IDLE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
      // Both enables together abort whatever pulse is in flight.
      if (both_en && !clearing) begin
         state_nxt = S_ERR;
         err_set   = 1'b1;
      end
      rd_start = (state == S_IDLE) && (state_nxt == S_READ);
      wr_start = (state == S_IDLE) && (state_nxt == S_WRITE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_RST;
         ram_rdata <= '0;
         last_addr <= '0;
         valid_q   <= 1'b0;
         proto_err <= 1'b0;
         rd_count  <= '0;
         wr_count  <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            ram_rdata <= wr_en ? ram_wdata : mem[ram_addr];
            last_addr <= ram_addr;
         end
         valid_q <= capture & ~wr_en & (ram_addr == last_addr);
         if (err_set) proto_err <= 1'b1;
         if (rd_start && rd_count != '1) rd_count <= rd_count + 1'b1;
         if (wr_start && wr_count != '1) wr_count <= wr_count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_wr) mem[mem_wa] <= mem_wd;
   end
endmodule

// File: tb/tb_data_ram_responder.sv
// tb/tb_data_ram_responder.sv - scoreboard bench for data_ram_responder (default build and RAM_CLEAR_EN build).
module tb_data_ram_responder;
   logic        clk, rst;
   logic        cs, re, we;
   logic [7:0]  addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        rd_valid, busy, proto_err;
   logic [7:0]  rd_count, wr_count;

   int          n_cmp = 0;
   int          n_err = 0;
   int          exp_rd = 0;
   int          exp_wr = 0;
   int          busy_cycles = 0;
   logic [15:0] exp_q[$];
   logic [15:0] e;

   data_ram_responder #(.AW(8), .DW(16), .CW(8)) dut (
      .clk(clk), .rst(rst), .ram_cs(cs), .ram_re(re), .ram_we(we),
      .ram_addr(addr), .ram_wdata(wdata), .ram_rdata(rdata), .rd_valid(rd_valid),
      .busy(busy), .proto_err(proto_err), .rd_count(rd_count), .wr_count(wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cs = 0; re = 0; we = 0; addr = 0; wdata = 0;
      rst = 1;
      step();
      step();
      rst = 0;
      #1;
      exp_rd = 0;
      exp_wr = 0;
      busy_cycles = 0;
`ifdef RAM_CLEAR_EN
      while (busy === 1'b1 && busy_cycles < 1000) begin
         step();
         busy_cycles++;
      end
`endif
   endtask

   task automatic test_reset();
      cs = 0; re = 0; we = 0; addr = 0; wdata = 0;
      rst = 1;
      step();
      n_cmp++; if (rdata !== 16'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0000", rdata); end
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_proto_err got %b want 0", proto_err); end
      n_cmp++; if (rd_count !== 8'h0) begin n_err++; $display("FAIL reset_rd_count got %h want 00", rd_count); end
      n_cmp++; if (wr_count !== 8'h0) begin n_err++; $display("FAIL reset_wr_count got %h want 00", wr_count); end
      do_reset();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ready_busy got %b want 0", busy); end
   endtask

`ifdef RAM_CLEAR_EN
   task automatic test_clear();
      n_cmp++; if (busy_cycles != 256) begin n_err++; $display("FAIL clear_busy_len got %0d want 256", busy_cycles); end
      rst = 1; step(); rst = 0; #1;
      for (int i = 0; i < 100; i++) step();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clear_busy_mid got %b want 1", busy); end
      rst = 1; #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clear_busy_in_rst got %b want 0", busy); end
      step(); rst = 0; #1;
      cs = 1; re = 1;
      step();
      busy_cycles = 1;
      cs = 0; re = 0;
      while (busy === 1'b1 && busy_cycles < 1000) begin
         step();
         busy_cycles++;
      end
      n_cmp++; if (busy_cycles != 256) begin n_err++; $display("FAIL clear_restart_len got %0d want 256", busy_cycles); end
      n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL clear_busy_err got %b want 1", proto_err); end
      n_cmp++; if (rd_count !== 8'h0) begin n_err++; $display("FAIL clear_busy_rd_count got %h want 00", rd_count); end
      cs = 1; addr = 8'hFF;
      exp_q.push_back(16'h0000);
      step(); step();
      e = exp_q.pop_front();
      n_cmp++; if (rdata !== e) begin n_err++; $display("FAIL clear_read_ff got %h want %h", rdata, e); end
      cs = 0;
      do_reset();
   endtask
`endif

   task automatic test_write_read();
      cs = 1; addr = 8'h12; wdata = 16'hBEEF; we = 1;
      exp_q.push_back(16'hBEEF);
      exp_wr++;
      step();
      e = exp_q.pop_front();
      n_cmp++; if (rdata !== e) begin n_err++; $display("FAIL wr_forward got %h want %h", rdata, e); end
      we = 0;
      step();
      re = 1;
      exp_q.push_back(16'hBEEF);
      exp_rd++;
      step();
      e = exp_q.pop_front();
      n_cmp++; if (rdata !== e) begin n_err++; $display("FAIL wr_read_data got %h want %h", rdata, e); end
      n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL wr_read_valid got %b want 1", rd_valid); end
      n_cmp++; if (wr_count !== 8'(exp_wr)) begin n_err++; $display("FAIL wr_read_wr_count got %h want %h", wr_count, 8'(exp_wr)); end
      n_cmp++; if (rd_count !== 8'(exp_rd)) begin n_err++; $display("FAIL wr_read_rd_count got %h want %h", rd_count, 8'(exp_rd)); end
      re = 0;
      step();
   endtask

   task automatic test_latency();
      addr = 8'h05; wdata = 16'h0001; we = 1; step(); we = 0; step();
      addr = 8'h06; wdata = 16'h0002; we = 1; step(); we = 0; step();
      exp_wr += 2;
      addr = 8'h05;
      exp_q.push_back(16'h0001);
      step(); step();
      e = exp_q.pop_front();
      n_cmp++; if (rdata !== e) begin n_err++; $display("FAIL lat_hold05 got %h want %h", rdata, e); end
      n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid05 got %b want 1", rd_valid); end
      addr = 8'h06;
      exp_q.push_back(16'h0002);
      #1;
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL lat_valid_after_change got %b want 0", rd_valid); end
      n_cmp++; if (rdata !== 16'h0001) begin n_err++; $display("FAIL lat_old_data got %h want 0001", rdata); end
      step();
      e = exp_q.pop_front();
      n_cmp++; if (rdata !== e) begin n_err++; $display("FAIL lat_new_data got %h want %h", rdata, e); end
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL lat_valid_n1 got %b want 0", rd_valid); end
      step();
      n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid_n2 got %b want 1", rd_valid); end
      cs = 0; addr = 8'h05;
      #1;
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL cs_low_valid got %b want 0", rd_valid); end
      step();
      n_cmp++; if (rdata !== 16'h0002) begin n_err++; $display("FAIL cs_low_hold got %h want 0002", rdata); end
      cs = 1;
      step();
   endtask

   task automatic test_forwarding();
      addr = 8'h20; wdata = 16'h1234; we = 1;
      exp_q.push_back(16'h1234);
      exp_wr++;
      step();
      e = exp_q.pop_front();
      n_cmp++; if (rdata !== e) begin n_err++; $display("FAIL fwd_same_edge got %h want %h", rdata, e); end
      we = 0;
      exp_q.push_back(16'h1234);
      step();
      e = exp_q.pop_front();
      n_cmp++; if (rdata !== e) begin n_err++; $display("FAIL fwd_mem got %h want %h", rdata, e); end
   endtask

   task automatic test_proto_err();
      addr = 8'h30; wdata = 16'hAAAA; we = 1; step(); we = 0; step();
      exp_wr++;
      n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL perr_before got %b want 0", proto_err); end
      re = 1; we = 1; wdata = 16'h5555;
      step();
      n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL perr_set got %b want 1", proto_err); end
      n_cmp++; if (wr_count !== 8'(exp_wr)) begin n_err++; $display("FAIL perr_wr_count got %h want %h", wr_count, 8'(exp_wr)); end
      n_cmp++; if (rd_count !== 8'(exp_rd)) begin n_err++; $display("FAIL perr_rd_count got %h want %h", rd_count, 8'(exp_rd)); end
      re = 0; we = 0;
      exp_q.push_back(16'hAAAA);
      step(); step();
      e = exp_q.pop_front();
      n_cmp++; if (rdata !== e) begin n_err++; $display("FAIL perr_mem_kept got %h want %h", rdata, e); end
      n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL perr_sticky got %b want 1", proto_err); end
   endtask

   task automatic test_level_and_saturation();
      addr = 8'h40; we = 1;
      wdata = 16'h0001; step();
      wdata = 16'h0002; step();
      wdata = 16'h0003; step();
      we = 0;
      exp_wr++;
      exp_q.push_back(16'h0003);
      step();
      e = exp_q.pop_front();
      n_cmp++; if (rdata !== e) begin n_err++; $display("FAIL level_last_wins got %h want %h", rdata, e); end
      n_cmp++; if (wr_count !== 8'(exp_wr)) begin n_err++; $display("FAIL level_count got %h want %h", wr_count, 8'(exp_wr)); end
      for (int i = 0; i < 300; i++) begin
         we = 1; wdata = 16'(i); step();
         we = 0; step();
         if (exp_wr < 255) exp_wr++;
         if (i == 99) begin
            n_cmp++; if (wr_count !== 8'(exp_wr)) begin n_err++; $display("FAIL sat_mid got %h want %h", wr_count, 8'(exp_wr)); end
         end
      end
      n_cmp++; if (wr_count !== 8'hFF) begin n_err++; $display("FAIL sat_final got %h want ff", wr_count); end
   endtask

   task automatic test_reset_mid();
      addr = 8'h50; wdata = 16'h1111; we = 1; step(); we = 0; step();
      wdata = 16'hDEAD; we = 1;
      #3;
      rst = 1;
      #1;
      n_cmp++; if (rdata !== 16'h0) begin n_err++; $display("FAIL rst_mid_rdata got %h want 0000", rdata); end
      n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL rst_mid_perr got %b want 0", proto_err); end
      n_cmp++; if (wr_count !== 8'h0) begin n_err++; $display("FAIL rst_mid_wr_count got %h want 00", wr_count); end
      n_cmp++; if (rd_count !== 8'h0) begin n_err++; $display("FAIL rst_mid_rd_count got %h want 00", rd_count); end
      step();
      we = 0;
      rst = 0;
      #1;
`ifdef RAM_CLEAR_EN
      exp_q.push_back(16'h0000);
      busy_cycles = 0;
      while (busy === 1'b1 && busy_cycles < 1000) begin
         step();
         busy_cycles++;
      end
`else
      exp_q.push_back(16'h1111);
`endif
      cs = 1; addr = 8'h50;
      step(); step();
      e = exp_q.pop_front();
      n_cmp++; if (rdata !== e) begin n_err++; $display("FAIL rst_write_dropped got %h want %h", rdata, e); end
      n_cmp++; if (wr_count !== 8'h0) begin n_err++; $display("FAIL rst_after_wr_count got %h want 00", wr_count); end
   endtask

   initial begin
      rst = 1; cs = 0; re = 0; we = 0; addr = 0; wdata = 0;
      test_reset();
`ifdef RAM_CLEAR_EN
      test_clear();
`endif
      test_write_read();
      test_latency();
      test_forwarding();
      test_proto_err();
      test_level_and_saturation();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
